// File: rtl/eqp_freq_meter.sv
// Equal-precision reciprocal frequency meter: gate aligned to sig_in edges.
// Build option: define EQP_CONTINUOUS_EN for automatic re-arm after each gate.
module eqp_freq_meter #(
  parameter int CNT_W       = 32,
  parameter int GATE_CYC    = 50000000,
  parameter int TIMEOUT_CYC = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             clr0,
  input  logic             start,
  input  logic             sig_in,
  input  logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             timeout,
  output logic             ovf,
  output logic [CNT_W-1:0] nx_cnt,
  output logic [CNT_W-1:0] ns_cnt,
  output logic [7:0]       rd_byte
);

  localparam int GW = $clog2(GATE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GATE_L  = GW'(GATE_CYC);
  localparam logic [GW-1:0] GATE_M1 = GW'(GATE_CYC - 1);
  localparam logic [TW-1:0] TO_L    = TW'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE, S_ARM, S_MEAS, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic [CNT_W-1:0] nx_q, nx_d;
  logic [CNT_W-1:0] ns_q, ns_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [TW-1:0]    wt_q, wt_d;
  logic             ovf_run_q, ovf_run_d;
  logic             to_run_q, to_run_d;
  logic [CNT_W-1:0] nx_res_q, nx_res_d;
  logic [CNT_W-1:0] ns_res_q, ns_res_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;
  logic             ovf_q, ovf_d;

  logic gate_full, gate_hit, to_lim;
  logic arm_to, meas_close, meas_to;
  logic [31:0] rd_word;

  // sig_in synchroniser chain plus edge-detect flop
  always_ff @(posedge clkin or posedge clr0) begin
    if (clr0) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign gate_full  = (gcnt_q == GATE_L);
  assign gate_hit   = (gcnt_q >= GATE_M1);
  assign to_lim     = (wt_q == TO_L);
  assign arm_to     = (state_q == S_ARM) && !rise && to_lim;
  assign meas_close = (state_q == S_MEAS) && rise && gate_hit;
  assign meas_to    = (state_q == S_MEAS) && !meas_close
                      && gate_full && to_lim;

  // FSM state register
  always_ff @(posedge clkin or posedge clr0) begin
    if (clr0) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; a closing edge beats the timeout limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        if (rise)        state_d = S_MEAS;
        else if (arm_to) state_d = S_DONE;
      end
      S_MEAS: begin
        if (meas_close || meas_to) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef EQP_CONTINUOUS_EN
        state_d = S_ARM;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == S_ARM) || (state_q == S_MEAS);
    done = (state_q == S_DONE);
  end

  // counters, timers and result latching
  always_comb begin
    nx_d      = nx_q;
    ns_d      = ns_q;
    gcnt_d    = gcnt_q;
    wt_d      = wt_q;
    ovf_run_d = ovf_run_q;
    to_run_d  = to_run_q;
    nx_res_d  = nx_res_q;
    ns_res_d  = ns_res_q;
    valid_d   = valid_q;
    to_d      = to_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wt_d      = '0;
          valid_d   = 1'b0;
          to_d      = 1'b0;
          ovf_d     = 1'b0;
          ovf_run_d = 1'b0;
          to_run_d  = 1'b0;
        end
      end
      S_ARM: begin
        if (rise) begin
          nx_d      = '0;
          ns_d      = '0;
          gcnt_d    = '0;
          wt_d      = '0;
          ovf_run_d = 1'b0;
        end else begin
          if (!to_lim) wt_d = wt_q + 1'b1;
          to_run_d = arm_to;
        end
      end
      S_MEAS: begin
        if (ns_q == CMAX) ovf_run_d = 1'b1;
        else              ns_d = ns_q + 1'b1;
        if (rise) begin
          if (nx_q == CMAX) ovf_run_d = 1'b1;
          else              nx_d = nx_q + 1'b1;
        end
        if (!gate_full) gcnt_d = gcnt_q + 1'b1;
        if (!gate_full)   wt_d = '0;
        else if (!to_lim) wt_d = wt_q + 1'b1;
        to_run_d = meas_to;
      end
      S_DONE: begin
        if (!to_run_q) begin
          nx_res_d = nx_q;
          ns_res_d = ns_q;
        end
        valid_d  = !to_run_q;
        to_d     = to_run_q;
        ovf_d    = ovf_run_q;
        wt_d     = '0;
        to_run_d = 1'b0;
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clkin or posedge clr0) begin
    if (clr0) begin
      nx_q      <= '0;
      ns_q      <= '0;
      gcnt_q    <= '0;
      wt_q      <= '0;
      ovf_run_q <= 1'b0;
      to_run_q  <= 1'b0;
      nx_res_q  <= '0;
      ns_res_q  <= '0;
      valid_q   <= 1'b0;
      to_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      nx_q      <= nx_d;
      ns_q      <= ns_d;
      gcnt_q    <= gcnt_d;
      wt_q      <= wt_d;
      ovf_run_q <= ovf_run_d;
      to_run_q  <= to_run_d;
      nx_res_q  <= nx_res_d;
      ns_res_q  <= ns_res_d;
      valid_q   <= valid_d;
      to_q      <= to_d;
      ovf_q     <= ovf_d;
    end
  end

  // byte readout; bytes beyond CNT_W read as zero
  always_comb begin
    rd_word = '0;
    rd_word[CNT_W-1:0] = sel[2] ? ns_res_q : nx_res_q;
    rd_byte = rd_word[{sel[1:0], 3'b000} +: 8];
  end

  assign valid   = valid_q;
  assign timeout = to_q;
  assign ovf     = ovf_q;
  assign nx_cnt  = nx_res_q;
  assign ns_cnt  = ns_res_q;

endmodule

// File: tb/tb_eqp_freq_meter.sv
// Directed bench for eqp_freq_meter.
// u0: 32-bit, gate 100; u1: 8-bit, gate 300 (saturation).
module tb_eqp_freq_meter;

  logic       clkin;
  logic       clr0;
  logic       start0, start1;
  logic       sig_in;
  logic [2:0] sel;

  logic        busy0, done0, valid0, timeout0, ovf0;
  logic [31:0] nx0, ns0;
  logic [7:0]  rd0;
  logic        busy1, done1, valid1, timeout1, ovf1;
  logic [7:0]  nx1, ns1;
  logic [7:0]  rd1;

  int n_chk;
  int n_fail;
  int per;
  int cyc;

  eqp_freq_meter #(
    .CNT_W(32), .GATE_CYC(100), .TIMEOUT_CYC(50), .SYNC_STAGES(2)
  ) u0 (
    .clkin(clkin), .clr0(clr0), .start(start0), .sig_in(sig_in),
    .sel(sel), .busy(busy0), .done(done0), .valid(valid0),
    .timeout(timeout0), .ovf(ovf0), .nx_cnt(nx0), .ns_cnt(ns0),
    .rd_byte(rd0)
  );

  eqp_freq_meter #(
    .CNT_W(8), .GATE_CYC(300), .TIMEOUT_CYC(50), .SYNC_STAGES(2)
  ) u1 (
    .clkin(clkin), .clr0(clr0), .start(start1), .sig_in(sig_in),
    .sel(sel), .busy(busy1), .done(done1), .valid(valid1),
    .timeout(timeout1), .ovf(ovf1), .nx_cnt(nx1), .ns_cnt(ns1),
    .rd_byte(rd1)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // sig_in generator: period 'per' clkin cycles, 0 = held low
  initial begin
    int cnt;
    cnt = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clkin);
      #2;
      if (per <= 0) begin
        sig_in = 1'b0;
        cnt = 0;
      end else begin
        cnt = (cnt + 1) % per;
        sig_in = (cnt < per / 2);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task pulse0();
    @(negedge clkin);
    start0 = 1'b1;
    @(negedge clkin);
    start0 = 1'b0;
  endtask

  task pulse1();
    @(negedge clkin);
    start1 = 1'b1;
    @(negedge clkin);
    start1 = 1'b0;
  endtask

  task wait_done0(input int budget, output int c);
    c = 0;
    while (done0 !== 1'b1 && c < budget) begin
      @(negedge clkin);
      c++;
    end
  endtask

  task wait_done1(input int budget, output int c);
    c = 0;
    while (done1 !== 1'b1 && c < budget) begin
      @(negedge clkin);
      c++;
    end
  endtask

  task test_reset();
    clr0 = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    sel = 3'd0;
    per = 0;
    repeat (3) @(negedge clkin);
    n_chk++;
    if ({busy0, done0, valid0, timeout0, ovf0} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags0: got %b want 00000",
               {busy0, done0, valid0, timeout0, ovf0});
    end
    n_chk++;
    if (nx0 !== 32'd0 || ns0 !== 32'd0 || rd0 !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_cnt0: got nx=%0d ns=%0d rd=%0d want 0",
               nx0, ns0, rd0);
    end
    n_chk++;
    if ({busy1, done1, valid1, timeout1, ovf1} !== 5'b0 ||
        nx1 !== 8'd0 || ns1 !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_u1: got flags=%b nx=%0d ns=%0d want 0",
               {busy1, done1, valid1, timeout1, ovf1}, nx1, ns1);
    end
    clr0 = 1'b0;
    repeat (2) @(negedge clkin);
  endtask

  task test_basic();
    per = 10;
    repeat (30) @(negedge clkin);
    pulse0();
    n_chk++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on: got %b want 1", busy0);
    end
    repeat (30) @(negedge clkin);
    start0 = 1'b1;
    @(negedge clkin);
    start0 = 1'b0;
    wait_done0(300, cyc);
    n_chk++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL basic_done: got timeout after %0d want <300", cyc);
    end
    @(negedge clkin);
    n_chk++;
    if (done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_1cyc: got %b want 0", done0);
    end
    n_chk++;
    if (nx0 !== 32'd10 || ns0 !== 32'd100) begin
      n_fail++;
      $display("FAIL basic_cnt: got nx=%0d ns=%0d want 10/100",
               nx0, ns0);
    end
    n_chk++;
    if ({valid0, timeout0, ovf0, busy0} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_flags: got %b want 1000",
               {valid0, timeout0, ovf0, busy0});
    end
    repeat (5) @(negedge clkin);
    n_chk++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL no_rerun: got busy=%b want 0", busy0);
    end
  endtask

  task test_period7();
    per = 7;
    repeat (30) @(negedge clkin);
    pulse0();
    n_chk++;
    if (valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_clr: got %b want 0", valid0);
    end
    wait_done0(300, cyc);
    n_chk++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL p7_done: got timeout after %0d want <300", cyc);
    end
    @(negedge clkin);
    n_chk++;
    if (nx0 !== 32'd15 || ns0 !== 32'd105 || ovf0 !== 1'b0) begin
      n_fail++;
      $display("FAIL p7_cnt: got nx=%0d ns=%0d ovf=%b want 15/105/0",
               nx0, ns0, ovf0);
    end
    sel = 3'd4;
    #1;
    n_chk++;
    if (rd0 !== 8'd105) begin
      n_fail++;
      $display("FAIL rd_sel4: got %0d want 105", rd0);
    end
    sel = 3'd0;
    #1;
    n_chk++;
    if (rd0 !== 8'd15) begin
      n_fail++;
      $display("FAIL rd_sel0: got %0d want 15", rd0);
    end
    sel = 3'd7;
    #1;
    n_chk++;
    if (rd0 !== 8'd0) begin
      n_fail++;
      $display("FAIL rd_sel7: got %0d want 0", rd0);
    end
  endtask

  task test_timeout();
    per = 0;
    repeat (10) @(negedge clkin);
    pulse0();
    wait_done0(200, cyc);
    n_chk++;
    if (cyc < 48 || cyc > 54) begin
      n_fail++;
      $display("FAIL to_latency: got %0d want 48..54", cyc);
    end
    @(negedge clkin);
    n_chk++;
    if (timeout0 !== 1'b1 || valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL to_flags: got to=%b valid=%b want 1/0",
               timeout0, valid0);
    end
    n_chk++;
    if (nx0 !== 32'd15 || ns0 !== 32'd105) begin
      n_fail++;
      $display("FAIL to_keep: got nx=%0d ns=%0d want 15/105", nx0, ns0);
    end
  endtask

  task test_saturate();
    int pulses;
    per = 10;
    repeat (30) @(negedge clkin);
    pulse1();
    wait_done1(800, cyc);
    n_chk++;
    if (cyc >= 800) begin
      n_fail++;
      $display("FAIL sat_done: got timeout after %0d want <800", cyc);
    end
    @(negedge clkin);
    n_chk++;
    if (nx1 !== 8'd30 || ns1 !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cnt: got nx=%0d ns=%0d want 30/255", nx1, ns1);
    end
    n_chk++;
    if (ovf1 !== 1'b1 || valid1 !== 1'b1 || timeout1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_flags: got ovf=%b valid=%b to=%b want 1/1/0",
               ovf1, valid1, timeout1);
    end
    sel = 3'd4;
    #1;
    n_chk++;
    if (rd1 !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_rd4: got %0d want 255", rd1);
    end
    sel = 3'd5;
    #1;
    n_chk++;
    if (rd1 !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_rd5: got %0d want 0", rd1);
    end
    sel = 3'd1;
    #1;
    n_chk++;
    if (rd1 !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_rd1: got %0d want 0", rd1);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clkin);
      if (done1 === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL sat_once: got %0d extra done want 0", pulses);
    end
  endtask

  task test_reset_mid();
    per = 10;
    repeat (20) @(negedge clkin);
    pulse0();
    repeat (60) @(negedge clkin);
    clr0 = 1'b1;
    @(negedge clkin);
    n_chk++;
    if ({busy0, done0, valid0, timeout0, ovf0} !== 5'b0 ||
        nx0 !== 32'd0 || ns0 !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_rst: got flags=%b nx=%0d ns=%0d want 0",
               {busy0, done0, valid0, timeout0, ovf0}, nx0, ns0);
    end
    clr0 = 1'b0;
    repeat (3) @(negedge clkin);
    pulse0();
    wait_done0(300, cyc);
    n_chk++;
    if (cyc >= 300) begin
      n_fail++;
      $display("FAIL mid_done: got timeout after %0d want <300", cyc);
    end
    @(negedge clkin);
    n_chk++;
    if (nx0 !== 32'd10 || ns0 !== 32'd100 || valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_cnt: got nx=%0d ns=%0d v=%b want 10/100/1",
               nx0, ns0, valid0);
    end
  endtask

  task test_continuous();
    per = 10;
    repeat (30) @(negedge clkin);
    pulse0();
    for (int k = 0; k < 3; k++) begin
      wait_done0(400, cyc);
      n_chk++;
      if (cyc >= 400) begin
        n_fail++;
        $display("FAIL cont_done%0d: got timeout want done", k);
      end
      if (k > 0) begin
        n_chk++;
        if (cyc < 100 || cyc > 120) begin
          n_fail++;
          $display("FAIL cont_gap%0d: got %0d want 100..120", k, cyc);
        end
      end
      @(negedge clkin);
      n_chk++;
      if (nx0 !== 32'd10 || ns0 !== 32'd100 || valid0 !== 1'b1) begin
        n_fail++;
        $display("FAIL cont_cnt%0d: got nx=%0d ns=%0d v=%b want 10/100/1",
                 k, nx0, ns0, valid0);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
`ifdef EQP_CONTINUOUS_EN
    test_continuous();
`else
    test_basic();
    test_period7();
    test_timeout();
    test_saturate();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
